posterise_pipe: RTL and testbench
=================================

Name: posterise_pipe

Overview:
Pipelined, parametrised successor to the combinational posteriser in the video_fx chain. It quantises each colour channel by discarding a mode-selected number of LSBs and refilling them with a selectable pattern, with optional 2x2 ordered (Bayer) dither. Configuration is frame-synchronous, so mode changes never tear mid-frame. It sits inline on the pixel bus between video sources and the output mixer, and carries sync signals through with matched latency.

Parameters:
CH_W, 8, bits per colour channel
N_CH, 3, channels per pixel; channel 0 is the LSB field, the highest channel is the MSB field (e.g. R,G,B = ch2,ch1,ch0)
MODE_W, 3, width of mode input
X_W, 12, width of the internal pixel and line counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
vid_in_data  in  N_CH*CH_W  input pixel
vid_in_valid  in  1  pixel qualifier
vid_in_hsync  in  1  line sync, active high
vid_in_vsync  in  1  frame sync, active high
mode  in  MODE_W  quantise level request
fill_sel  in  2  fill pattern request
dither_en  in  1  ordered dither request
vid_out_data  out  N_CH*CH_W  processed pixel
vid_out_valid  out  1  delayed vid_in_valid
vid_out_hsync  out  1  delayed vid_in_hsync
vid_out_vsync  out  1  delayed vid_in_vsync

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: all outputs 0; pipeline registers 0; active config = mode 0 (bypass), fill_sel 0, dither 0; x and y counters 0; edge-detect history 0.
- Config latch:
  - Active config loads from mode, fill_sel and dither_en on the cycle a vsync rising edge is detected (vid_in_vsync=1, previous=0).
  - The pixel presented on that edge cycle still uses the old config; the new config applies from the next cycle.
  - Requests that change mid-frame are ignored until the next vsync edge.
- Discard count d:
  - m = active mode. d = CH_W - m for 1 <= m <= CH_W-1.
  - m = 0 or m >= CH_W: bypass (d = 0; data passes unchanged, dither not applied).
  - With CH_W=8: mode1 gives d=7, mode5 gives d=3. Mode2 uses a mask of 63, not the legacy odd mask 61.
- Counters:
  - x increments on each valid pixel, saturates at 2^X_W-1, and clears on an hsync rising edge.
  - y increments on an hsync rising edge and clears on a vsync rising edge; clear wins over increment.
  - Only x[0] and y[0] are consumed.
- Stage 1 (register):
  - Per channel, sum = ch + off, saturating at 2^CH_W-1.
  - off = (B[y0][x0] << d) >> 2 when dither is active and d > 0, else 0.
  - B = [[0,2],[3,1]], indexed [y][x]. For d < 2 the offset truncates naturally and may be 0.
  - d and fill are piped alongside the data.
- Stage 2 (register): top CH_W-d bits of sum are kept; the low d bits are set by fill:
  - 0 = all ones (legacy behaviour)
  - 1 = all zeros
  - 2 = mid-level: bit d-1 set, remaining low bits 0
  - 3 = treated as 0
- Latency: exactly 2 cycles from input to output for data, valid, hsync and vsync. No backpressure; a new pixel is accepted every cycle.
- Invalid cycles: data is still processed (don't-care content), and valid is propagated as 0.
- Reset mid-stream: in-flight pixels are dropped, outputs are 0 on the cycle after rst is sampled high, and the block restarts in bypass.

Decomposition:
- posterise_pkg holds:
  - fill_t enum (FILL_ONES, FILL_ZEROS, FILL_HALF)
  - the 2x2 Bayer LUT constant
  - function discard_bits(mode, CH_W)
  - function sat_add
- Sub-module posterise_chan performs the per-channel saturating add plus mask/fill. It is instantiated N_CH times via generate.
- Top level owns the counters, edge detects, config latch and sync delay line.

Test Plan:
- Legacy equivalence: vsync edge with mode=1, fill=0; then input 0x1280FF -> output 0x7FFFFF exactly 2 cycles later, with valid, hsync and vsync delayed by 2 cycles.
- Fill patterns: mode=5 (d=3), input ch=0xAB:
  - fill=1 -> 0xA8
  - fill=2 -> 0xAC
  - fill=0 -> 0xAF
- Dither: mode=4 (d=4), fill=1, dither=1, ch=0x37:
  - (x0,y0)=(0,0) -> 0x30
  - (1,0) -> 0x30 (0x37+8=0x3F)
  - (0,1) -> 0x40 (0x37+12=0x43)
  - ch=0xFE at (0,1) -> saturates to 0xFF -> 0xF0
- Frame sync: change mode from 0 to 1 mid-frame -> output stays equal to input until after the next vsync edge. The pixel on the edge cycle is unprocessed; the next pixel is posterised.
- Bypass: mode=0 and mode=8-style values with MODE_W=4, CH_W=8 -> output equals input, dither has no effect.
- Reset: assert rst for 1 cycle mid-line -> outputs 0 on the next cycle, then bypass with counters restarted at (0,0).

Source files
------------

// File: rtl/posterise_pkg.sv
// Shared types, dither matrix and arithmetic helpers for the posteriser pipeline.
package posterise_pkg;

  typedef enum logic [1:0] {
    FILL_ONES  = 2'd0,
    FILL_ZEROS = 2'd1,
    FILL_HALF  = 2'd2
  } fill_t;

  // 2x2 ordered dither thresholds, indexed [y0][x0]
  localparam logic [1:0] BAYER [2][2] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  // Mode 0 and modes at or beyond the channel width are bypass (nothing discarded).
  function automatic int unsigned discard_bits(input int unsigned mode, input int unsigned ch_w);
    if (mode == 0 || mode >= ch_w) return 0;
    return ch_w - mode;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned max_v);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    if (s > longint'(max_v)) return max_v;
    return a + b;
  endfunction

endpackage

// File: rtl/posterise_chan.sv
// One colour channel: saturating dither add (stage 1), then LSB mask and refill (stage 2).
module posterise_chan
  import posterise_pkg::*;
#(
  parameter int CH_W = 8,
  parameter int D_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] ch_i,
  input  logic [CH_W-1:0] off_i,
  input  logic [D_W-1:0]  d_i,
  input  logic [1:0]      fill_i,
  output logic [CH_W-1:0] pix_o
);

  logic [CH_W-1:0] sum_q, sum_d;
  logic [CH_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0] mask, half, low;

  assign sum_d = CH_W'(sat_add(32'(ch_i), 32'(off_i), 32'({CH_W{1'b1}})));

  // d_i and fill_i are already aligned with sum_q by the top level
  assign mask = {CH_W{1'b1}} << d_i;
  assign half = (CH_W'(1) << d_i) >> 1;

  always_comb begin
    low = ~mask;
    case (fill_i)
      FILL_ZEROS: low = '0;
      FILL_HALF:  low = half;
      default:    low = ~mask;
    endcase
    pix_d = (sum_q & mask) | low;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      pix_q <= '0;
    end else begin
      sum_q <= sum_d;
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/posterise_pipe.sv
// Two-stage posteriser with frame-synchronous config and optional 2x2 ordered dither.
module posterise_pipe
  import posterise_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int N_CH   = 3,
  parameter int MODE_W = 3,
  parameter int X_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*CH_W-1:0] vid_in_data,
  input  logic                 vid_in_valid,
  input  logic                 vid_in_hsync,
  input  logic                 vid_in_vsync,
  input  logic [MODE_W-1:0]    mode,
  input  logic [1:0]           fill_sel,
  input  logic                 dither_en,
  output logic [N_CH*CH_W-1:0] vid_out_data,
  output logic                 vid_out_valid,
  output logic                 vid_out_hsync,
  output logic                 vid_out_vsync
);

  localparam int D_W = $clog2(CH_W + 1);

  logic              vs_prev_q, hs_prev_q;
  logic              vs_edge, hs_edge;
  logic [MODE_W-1:0] mode_q;
  logic [1:0]        fill_q;
  logic              dith_q;
  logic [X_W-1:0]    x_q, x_d, y_q, y_d;
  logic [D_W-1:0]    disc;
  logic [CH_W-1:0]   off;

  logic [D_W-1:0]    disc_s1_q;
  logic [1:0]        fill_s1_q;
  logic              valid_s1_q, hs_s1_q, vs_s1_q;
  logic              valid_q, hs_q, vs_q;

  assign vs_edge = vid_in_vsync & ~vs_prev_q;
  assign hs_edge = vid_in_hsync & ~hs_prev_q;

  always_comb begin
    x_d = x_q;
    if (hs_edge) x_d = '0;
    else if (vid_in_valid && x_q != {X_W{1'b1}}) x_d = x_q + X_W'(1);
    y_d = y_q;
    if (vs_edge) y_d = '0;
    else if (hs_edge) y_d = y_q + X_W'(1);
  end

  // The current pixel is processed with the config and position held before this edge.
  assign disc = D_W'(discard_bits(32'(mode_q), CH_W));

  always_comb begin
    off = '0;
    if (dith_q && disc != '0)
      off = CH_W'((32'(BAYER[y_q[0]][x_q[0]]) << disc) >> 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
      mode_q     <= '0;
      fill_q     <= '0;
      dith_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      disc_s1_q  <= '0;
      fill_s1_q  <= '0;
      valid_s1_q <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      valid_q    <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      vs_prev_q <= vid_in_vsync;
      hs_prev_q <= vid_in_hsync;
      if (vs_edge) begin
        mode_q <= mode;
        fill_q <= fill_sel;
        dith_q <= dither_en;
      end
      x_q        <= x_d;
      y_q        <= y_d;
      disc_s1_q  <= disc;
      fill_s1_q  <= fill_q;
      valid_s1_q <= vid_in_valid;
      hs_s1_q    <= vid_in_hsync;
      vs_s1_q    <= vid_in_vsync;
      valid_q    <= valid_s1_q;
      hs_q       <= hs_s1_q;
      vs_q       <= vs_s1_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    posterise_chan #(
      .CH_W (CH_W),
      .D_W  (D_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .ch_i   (vid_in_data[c*CH_W +: CH_W]),
      .off_i  (off),
      .d_i    (disc_s1_q),
      .fill_i (fill_s1_q),
      .pix_o  (vid_out_data[c*CH_W +: CH_W])
    );
  end

  assign vid_out_valid = valid_q;
  assign vid_out_hsync = hs_q;
  assign vid_out_vsync = vs_q;

endmodule

// File: tb/tb_posterise_pipe.sv
// Bench for posterise_pipe: constant vectors, hand sequences and a random run against an arithmetic model.
module tb_posterise_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] vid_in_data;
  logic        vid_in_valid, vid_in_hsync, vid_in_vsync;
  logic [3:0]  mode;
  logic [1:0]  fill_sel;
  logic        dither_en;
  logic [23:0] vid_out_data;
  logic        vid_out_valid, vid_out_hsync, vid_out_vsync;

  posterise_pipe #(.CH_W(8), .N_CH(3), .MODE_W(4), .X_W(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .vid_in_data   (vid_in_data),
    .vid_in_valid  (vid_in_valid),
    .vid_in_hsync  (vid_in_hsync),
    .vid_in_vsync  (vid_in_vsync),
    .mode          (mode),
    .fill_sel      (fill_sel),
    .dither_en     (dither_en),
    .vid_out_data  (vid_out_data),
    .vid_out_valid (vid_out_valid),
    .vid_out_hsync (vid_out_hsync),
    .vid_out_vsync (vid_out_vsync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        v, h, vs;
  } beat_t;

  typedef struct {
    logic [23:0] pix;
    logic [3:0]  md;
    logic [1:0]  fl;
    bit          de;
    bit          x0, y0;
    logic [23:0] exp;
  } vec_t;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] req_mode;
  logic [1:0] req_fill;
  bit         req_dith;

  // reference model state
  int    m_mode, m_fill, mx, my;
  bit    m_dith, m_vsp, m_hsp;
  beat_t m_s1, m_out;

  function automatic logic [23:0] ref_pix(input logic [23:0] p, input int md, input int fl,
                                          input bit de, input int x0, input int y0);
    int d, off, s, q, step;
    int bay [2][2];
    logic [23:0] r;
    bay = '{'{0, 2}, '{3, 1}};
    d = (md == 0 || md >= 8) ? 0 : 8 - md;
    step = 1 << d;
    off = (de && d > 0) ? (bay[y0][x0] * step) / 4 : 0;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = int'(p[c*8 +: 8]) + off;
      if (s > 255) s = 255;
      q = (s / step) * step;
      if (fl == 1) q = q;
      else if (fl == 2) q = q + step / 2;
      else q = q + step - 1;
      r[c*8 +: 8] = 8'(q);
    end
    return r;
  endfunction

  task automatic cycle(input logic [23:0] d, input bit v, input bit h, input bit vs,
                       input bit r = 1'b0);
    beat_t e;
    bit vse, hse;
    rst = r; vid_in_data = d; vid_in_valid = v; vid_in_hsync = h; vid_in_vsync = vs;
    mode = req_mode; fill_sel = req_fill; dither_en = req_dith;
    e = '0;
    if (r) begin
      m_mode = 0; m_fill = 0; m_dith = 0; mx = 0; my = 0; m_vsp = 0; m_hsp = 0;
    end else begin
      vse = vs && !m_vsp;
      hse = h && !m_hsp;
      e.data = ref_pix(d, m_mode, m_fill, m_dith, mx % 2, my % 2);
      e.v = v; e.h = h; e.vs = vs;
      if (vse) begin
        m_mode = int'(req_mode); m_fill = int'(req_fill); m_dith = req_dith;
      end
      if (hse) mx = 0;
      else if (v && mx < 4095) mx++;
      if (vse) my = 0;
      else if (hse) my++;
      m_vsp = vs; m_hsp = h;
    end
    @(posedge clk); #1;
    if (r) begin
      m_out = '0; m_s1 = '0;
    end else begin
      m_out = m_s1; m_s1 = e;
    end
    n_total++;
    if ({vid_out_data, vid_out_valid, vid_out_hsync, vid_out_vsync} !== m_out) begin
      n_bad++;
      $display("FAIL model t=%0t: got data=%h v=%b h=%b vs=%b want data=%h v=%b h=%b vs=%b",
               $time, vid_out_data, vid_out_valid, vid_out_hsync, vid_out_vsync,
               m_out.data, m_out.v, m_out.h, m_out.vs);
    end
  endtask

  task automatic check_data(input string name, input logic [23:0] exp);
    n_total++;
    if (vid_out_data !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, vid_out_data, exp);
    end
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{24'h1280FF, 4'd1,  2'd0, 1'b0, 1'b0, 1'b0, 24'h7FFFFF};
    tbl[1]  = '{24'hABABAB, 4'd5,  2'd1, 1'b0, 1'b0, 1'b0, 24'hA8A8A8};
    tbl[2]  = '{24'hABABAB, 4'd5,  2'd2, 1'b0, 1'b0, 1'b0, 24'hACACAC};
    tbl[3]  = '{24'hABABAB, 4'd5,  2'd0, 1'b0, 1'b0, 1'b0, 24'hAFAFAF};
    tbl[4]  = '{24'h373737, 4'd4,  2'd1, 1'b1, 1'b0, 1'b0, 24'h303030};
    tbl[5]  = '{24'h373737, 4'd4,  2'd1, 1'b1, 1'b1, 1'b0, 24'h303030};
    tbl[6]  = '{24'h373737, 4'd4,  2'd1, 1'b1, 1'b0, 1'b1, 24'h404040};
    tbl[7]  = '{24'hFEFEFE, 4'd4,  2'd1, 1'b1, 1'b0, 1'b1, 24'hF0F0F0};
    tbl[8]  = '{24'h000000, 4'd2,  2'd0, 1'b0, 1'b0, 1'b0, 24'h3F3F3F};
    tbl[9]  = '{24'h123456, 4'd0,  2'd1, 1'b1, 1'b1, 1'b1, 24'h123456};
    tbl[10] = '{24'h123456, 4'd8,  2'd2, 1'b1, 1'b0, 1'b1, 24'h123456};
    tbl[11] = '{24'hA5C3E1, 4'd15, 2'd1, 1'b1, 1'b1, 1'b0, 24'hA5C3E1};
    tbl[12] = '{24'h01FF80, 4'd3,  2'd3, 1'b0, 1'b0, 1'b0, 24'h1FFF9F};
    tbl[13] = '{24'h404040, 4'd7,  2'd2, 1'b1, 1'b1, 1'b1, 24'h414141};

    req_mode = 4'd1; req_fill = 2'd0; req_dith = 1'b0;
    cycle(24'hFFFFFF, 1, 1, 1, 1'b1);
    check_data("reset_state", 24'h0);
    cycle(24'h0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      req_mode = tbl[i].md; req_fill = tbl[i].fl; req_dith = tbl[i].de;
      cycle(24'h0, 0, 1, 1);
      cycle(24'h0, 0, 0, 0);
      if (tbl[i].y0) begin
        cycle(24'h0, 0, 1, 0);
        cycle(24'h0, 0, 0, 0);
      end
      if (tbl[i].x0) cycle(24'h0, 1, 0, 0);
      cycle(tbl[i].pix, 1, 0, 0);
      cycle(24'h0, 0, 0, 0);
      check_data($sformatf("vec%0d", i), tbl[i].exp);
    end

    // config request changes mid-frame; takes effect only after the next vsync edge
    req_mode = 4'd0; req_fill = 2'd0; req_dith = 1'b0;
    cycle(24'h0, 0, 1, 1);
    cycle(24'h0, 0, 0, 0);
    req_mode = 4'd1;
    cycle(24'h123456, 1, 0, 0);
    cycle(24'h654321, 1, 0, 1);
    check_data("frame_mid", 24'h123456);
    cycle(24'h123456, 1, 0, 0);
    check_data("frame_edge_pix", 24'h654321);
    cycle(24'h0, 0, 0, 0);
    check_data("frame_after", 24'h7F7F7F);

    // reset mid-line with x left odd, then counters must restart at (0,0)
    req_mode = 4'd4; req_fill = 2'd1; req_dith = 1'b1;
    cycle(24'h0, 0, 1, 1);
    cycle(24'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(24'h3A3A3A, 1, 0, 0);
    cycle(24'h111111, 1, 0, 0, 1'b1);
    check_data("reset_out_zero", 24'h0);
    cycle(24'hC0FFEE, 0, 0, 0);
    cycle(24'h0, 0, 0, 0);
    check_data("reset_bypass", 24'hC0FFEE);
    cycle(24'h0, 0, 0, 1);
    cycle(24'h0, 0, 0, 0);
    cycle(24'h3A3A3A, 1, 0, 0);
    cycle(24'h0, 0, 0, 0);
    check_data("reset_xy_origin", 24'h303030);

    for (int i = 0; i < 3000; i++) begin
      req_mode = 4'($urandom_range(0, 15));
      req_fill = 2'($urandom_range(0, 3));
      req_dith = 1'($urandom_range(0, 1));
      cycle(24'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
